// File: rtl/stage_ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: opcodes, bus widths,
// counter terminal value and the reset polarity.
package stage_ex_mem_pkg;

    localparam int OPCODE_W    = 7;
    localparam int FUNCT3_W    = 3;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_W       = 32;
    localparam int INST_ADDR_W = 32;
    localparam int CNT_W       = 4;
    localparam int WDOG_LIMIT  = 32;

    typedef logic [OPCODE_W-1:0]    opcode_bus_t;
    typedef logic [FUNCT3_W-1:0]    funct_bus3_t;
    typedef logic [REG_ADDR_W-1:0]  reg_addr_bus_t;
    typedef logic [REG_W-1:0]       reg_bus_t;
    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
    typedef logic [CNT_W-1:0]       cnt_bus8_t;

    localparam opcode_bus_t   LOAD_OP      = 7'b0000011;
    localparam opcode_bus_t   STORE_OP     = 7'b0100011;
    localparam reg_addr_bus_t NOP_REG_ADDR = '0;
    localparam reg_bus_t      ZERO_WORD    = '0;
    localparam cnt_bus8_t     CNT_DONE     = 4'b1000;
    localparam logic          RST_ACTIVE   = 1'b0;

    function automatic logic is_mem_op(input opcode_bus_t op);
        return (op == LOAD_OP) || (op == STORE_OP);
    endfunction

endpackage

// File: rtl/stage_ex_mem_if.sv
// EX/MEM stage bundle: EX payload and stall controls in, latched payload and
// byte-access counter out. master drives the stage, slave is the stage itself.
interface stage_ex_mem_if;

    logic                            rdy;
    stage_ex_mem_pkg::opcode_bus_t    ex_opcode_i;
    stage_ex_mem_pkg::funct_bus3_t    ex_funct3_i;
    stage_ex_mem_pkg::reg_addr_bus_t  ex_wd_i;
    logic                            ex_wreg_i;
    stage_ex_mem_pkg::reg_bus_t       ex_wdata_i;
    stage_ex_mem_pkg::inst_addr_bus_t ex_mem_addr_i;
    logic                            ex_stall_i;
    logic                            mem_stall_i;
    stage_ex_mem_pkg::cnt_bus8_t      mem_cnt_i;

    stage_ex_mem_pkg::opcode_bus_t    opcode_o;
    stage_ex_mem_pkg::funct_bus3_t    funct3_o;
    stage_ex_mem_pkg::reg_addr_bus_t  wd_o;
    logic                            wreg_o;
    stage_ex_mem_pkg::reg_bus_t       wdata_o;
    stage_ex_mem_pkg::inst_addr_bus_t mem_addr_o;
    stage_ex_mem_pkg::cnt_bus8_t      mem_cnt_o;
    logic                            mem_busy_o;
    logic                            mem_timeout_o;

    modport master (
        output rdy, ex_opcode_i, ex_funct3_i, ex_wd_i, ex_wreg_i, ex_wdata_i,
               ex_mem_addr_i, ex_stall_i, mem_stall_i, mem_cnt_i,
        input  opcode_o, funct3_o, wd_o, wreg_o, wdata_o, mem_addr_o,
               mem_cnt_o, mem_busy_o, mem_timeout_o
    );

    modport slave (
        input  rdy, ex_opcode_i, ex_funct3_i, ex_wd_i, ex_wreg_i, ex_wdata_i,
               ex_mem_addr_i, ex_stall_i, mem_stall_i, mem_cnt_i,
        output opcode_o, funct3_o, wd_o, wreg_o, wdata_o, mem_addr_o,
               mem_cnt_o, mem_busy_o, mem_timeout_o
    );

endinterface

// File: rtl/stage_ex_mem_wdog.sv
// Access watchdog: counts busy cycles of one stalled memory access and raises
// a sticky timeout once LIMIT is reached. Only built under MEM_WDOG_EN.
module mem_wdog #(
    parameter int LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic clr,
    input  logic busy,
    output logic fire,
    output logic timeout
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign fire = busy && (cnt == W'(LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (rdy) begin
            if (clr) begin
                cnt <= '0;
            end else if (busy && !fire) begin
                cnt <= cnt + 1'b1;
            end
            // a clear edge captures or bubbles, so the abort never lands then
            if (fire && !clr) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage_ex_mem.sv
// EX/MEM pipeline register with the byte-serial memory access counter.
// Optional access watchdog enabled by defining MEM_WDOG_EN.
module stage_ex_mem
    import stage_ex_mem_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    stage_ex_mem_if.slave  bus
);

    logic      mem_op;
    logic      busy;
    logic      wdog_fire;
    cnt_bus8_t cnt_in_sat;

    assign mem_op      = is_mem_op(bus.opcode_o);
    assign busy        = mem_op && (bus.mem_cnt_o != CNT_DONE);
    assign bus.mem_busy_o = busy;
    assign cnt_in_sat  = (bus.mem_cnt_i > CNT_DONE) ? CNT_DONE : bus.mem_cnt_i;

`ifdef MEM_WDOG_EN
    mem_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .rdy     (bus.rdy),
        .clr     (!bus.mem_stall_i),
        .busy    (busy),
        .fire    (wdog_fire),
        .timeout (bus.mem_timeout_o)
    );
`else
    assign wdog_fire         = 1'b0;
    assign bus.mem_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            bus.opcode_o   <= '0;
            bus.funct3_o   <= '0;
            bus.wd_o       <= NOP_REG_ADDR;
            bus.wreg_o     <= 1'b0;
            bus.wdata_o    <= ZERO_WORD;
            bus.mem_addr_o <= ZERO_WORD;
            bus.mem_cnt_o  <= CNT_DONE;
        end else if (bus.rdy) begin
            if (bus.mem_stall_i) begin
                // mem_cnt_i is only meaningful while an access is in flight
                if (wdog_fire) begin
                    bus.mem_cnt_o <= CNT_DONE;
                end else if (busy) begin
                    bus.mem_cnt_o <= cnt_in_sat;
                end
            end else if (bus.ex_stall_i) begin
                bus.opcode_o   <= '0;
                bus.funct3_o   <= '0;
                bus.wd_o       <= NOP_REG_ADDR;
                bus.wreg_o     <= 1'b0;
                bus.wdata_o    <= ZERO_WORD;
                bus.mem_addr_o <= ZERO_WORD;
                bus.mem_cnt_o  <= CNT_DONE;
            end else begin
                bus.opcode_o   <= bus.ex_opcode_i;
                bus.funct3_o   <= bus.ex_funct3_i;
                bus.wd_o       <= bus.ex_wd_i;
                bus.wreg_o     <= bus.ex_wreg_i;
                bus.wdata_o    <= bus.ex_wdata_i;
                bus.mem_addr_o <= bus.ex_mem_addr_i;
                bus.mem_cnt_o  <= is_mem_op(bus.ex_opcode_i) ? '0 : CNT_DONE;
            end
        end
    end

endmodule

// File: tb/tb_stage_ex_mem.sv
// Self-checking bench for stage_ex_mem: directed scenarios plus a randomized
// run against a cycle-level reference model of the pipeline register.
module tb_stage_ex_mem;

    logic clk = 1'b0;
    logic rst;

    stage_ex_mem_if bus ();

    stage_ex_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model of what the stage should be presenting
    logic [6:0]  m_opcode;
    logic [2:0]  m_funct3;
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_addr;
    int          m_cnt;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_IMM   = 7'd19;
    localparam logic [6:0] OP_REG   = 7'd51;

    function automatic logic is_mem(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE;
    endfunction

    function automatic logic m_busy();
        return is_mem(m_opcode) && m_cnt != 8;
    endfunction

    task automatic model_reset();
        m_opcode = 0; m_funct3 = 0; m_wd = 0; m_wreg = 0;
        m_wdata = 0; m_addr = 0; m_cnt = 8;
    endtask

    task automatic drive_ex(input logic [6:0] op, input logic [2:0] f3,
                            input logic [4:0] wd, input logic wreg,
                            input logic [31:0] wdata, input logic [31:0] addr);
        bus.ex_opcode_i   = op;
        bus.ex_funct3_i   = f3;
        bus.ex_wd_i       = wd;
        bus.ex_wreg_i     = wreg;
        bus.ex_wdata_i    = wdata;
        bus.ex_mem_addr_i = addr;
    endtask

    // advance one clock: model follows the stage's rules from current inputs
    task automatic step();
        if (bus.rdy) begin
            if (bus.mem_stall_i) begin
                if (m_busy()) m_cnt = (int'(bus.mem_cnt_i) > 8) ? 8 : int'(bus.mem_cnt_i);
            end else if (bus.ex_stall_i) begin
                model_reset();
            end else begin
                m_opcode = bus.ex_opcode_i;
                m_funct3 = bus.ex_funct3_i;
                m_wd     = bus.ex_wd_i;
                m_wreg   = bus.ex_wreg_i;
                m_wdata  = bus.ex_wdata_i;
                m_addr   = bus.ex_mem_addr_i;
                m_cnt    = is_mem(bus.ex_opcode_i) ? 0 : 8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rdy = 1'b1; bus.ex_stall_i = 0; bus.mem_stall_i = 0; bus.mem_cnt_i = 0;
        drive_ex(OP_IMM, 3'd7, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.opcode_o !== 7'd0 || bus.wdata_o !== 32'd0 || bus.mem_addr_o !== 32'd0 ||
            bus.wd_o !== 5'd0 || bus.wreg_o !== 1'b0 || bus.funct3_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_payload: op=%h wd=%h wdata=%h addr=%h expected all zero",
                     bus.opcode_o, bus.wd_o, bus.wdata_o, bus.mem_addr_o);
        end
        checks++;
        if (bus.mem_cnt_o !== 4'd8 || bus.mem_busy_o !== 1'b0 || bus.mem_timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt: cnt=%0d busy=%b tmo=%b expected 8/0/0",
                     bus.mem_cnt_o, bus.mem_busy_o, bus.mem_timeout_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_alu();
        drive_ex(OP_IMM, 3'd0, 5'd5, 1'b1, 32'h0000_002A, 32'h0);
        step();
        checks++;
        if (bus.wdata_o !== 32'h2A || bus.wd_o !== 5'd5 || bus.wreg_o !== 1'b1) begin
            failures++;
            $display("FAIL alu_payload: wdata=%h wd=%0d wreg=%b expected 2a/5/1",
                     bus.wdata_o, bus.wd_o, bus.wreg_o);
        end
        checks++;
        if (bus.mem_cnt_o !== 4'd8 || bus.mem_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL alu_cnt: cnt=%0d busy=%b expected 8/0", bus.mem_cnt_o, bus.mem_busy_o);
        end
    endtask

    task automatic test_lw_sequence();
        drive_ex(OP_LOAD, 3'd2, 5'd9, 1'b1, 32'h0, 32'h100);
        step();
        drive_ex(OP_IMM, 3'd1, 5'd2, 1'b0, 32'hDEAD, 32'hBEEF);
        bus.mem_stall_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (bus.mem_cnt_o !== 4'(i - 1) || bus.mem_busy_o !== 1'b1) begin
                failures++;
                $display("FAIL lw_step%0d: cnt=%0d busy=%b expected %0d/1",
                         i, bus.mem_cnt_o, bus.mem_busy_o, i - 1);
            end
            bus.mem_cnt_i = 4'(i);
            step();
        end
        checks++;
        if (bus.mem_cnt_o !== 4'd8 || bus.mem_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL lw_done: cnt=%0d busy=%b expected 8/0", bus.mem_cnt_o, bus.mem_busy_o);
        end
        checks++;
        if (bus.opcode_o !== OP_LOAD || bus.mem_addr_o !== 32'h100 || bus.wd_o !== 5'd9 ||
            bus.funct3_o !== 3'd2) begin
            failures++;
            $display("FAIL lw_payload_hold: op=%h addr=%h wd=%0d f3=%0d expected 03/100/9/2",
                     bus.opcode_o, bus.mem_addr_o, bus.wd_o, bus.funct3_o);
        end
        bus.mem_stall_i = 1'b0;
    endtask

    task automatic test_done_stalled();
        drive_ex(OP_STORE, 3'd0, 5'd0, 1'b0, 32'h55, 32'h204);
        step();
        bus.mem_stall_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.mem_cnt_i = 4'(i);
            step();
        end
        bus.mem_cnt_i = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.mem_cnt_o !== 4'd8 || bus.mem_busy_o !== 1'b0) begin
                failures++;
                $display("FAIL sb_done_hold%0d: cnt=%0d busy=%b expected 8/0",
                         i, bus.mem_cnt_o, bus.mem_busy_o);
            end
        end
        // back-to-back: next capture restarts the counter
        bus.mem_stall_i = 1'b0;
        drive_ex(OP_LOAD, 3'd4, 5'd3, 1'b1, 32'h0, 32'h300);
        step();
        checks++;
        if (bus.mem_cnt_o !== 4'd0 || bus.mem_busy_o !== 1'b1 || bus.mem_addr_o !== 32'h300) begin
            failures++;
            $display("FAIL back_to_back: cnt=%0d busy=%b addr=%h expected 0/1/300",
                     bus.mem_cnt_o, bus.mem_busy_o, bus.mem_addr_o);
        end
        // out-of-range counter value saturates at done
        bus.mem_stall_i = 1'b1;
        bus.mem_cnt_i   = 4'd13;
        step();
        checks++;
        if (bus.mem_cnt_o !== 4'd8 || bus.mem_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL cnt_saturate: cnt=%0d busy=%b expected 8/0", bus.mem_cnt_o, bus.mem_busy_o);
        end
        bus.mem_stall_i = 1'b0;
    endtask

    task automatic test_bubble_rdy();
        drive_ex(OP_REG, 3'd5, 5'd17, 1'b1, 32'h1234_5678, 32'h8);
        step();
        bus.ex_stall_i = 1'b1;
        step();
        checks++;
        if (bus.opcode_o !== 7'd0 || bus.wd_o !== 5'd0 || bus.wreg_o !== 1'b0 ||
            bus.wdata_o !== 32'd0 || bus.mem_addr_o !== 32'd0 || bus.mem_cnt_o !== 4'd8) begin
            failures++;
            $display("FAIL bubble: op=%h wd=%0d wreg=%b wdata=%h cnt=%0d expected zeros/8",
                     bus.opcode_o, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.mem_cnt_o);
        end
        bus.ex_stall_i = 1'b0;
        drive_ex(OP_STORE, 3'd1, 5'd4, 1'b0, 32'hCAFE, 32'h40);
        step();
        bus.rdy = 1'b0;
        drive_ex(OP_IMM, 3'd3, 5'd22, 1'b1, 32'h9999, 32'h7777);
        bus.mem_stall_i = 1'b1;
        bus.mem_cnt_i   = 4'd5;
        step();
        bus.mem_stall_i = 1'b0;
        step();
        checks++;
        if (bus.opcode_o !== OP_STORE || bus.wdata_o !== 32'hCAFE || bus.mem_addr_o !== 32'h40 ||
            bus.mem_cnt_o !== 4'd0 || bus.mem_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rdy_hold: op=%h wdata=%h addr=%h cnt=%0d busy=%b expected 23/cafe/40/0/1",
                     bus.opcode_o, bus.wdata_o, bus.mem_addr_o, bus.mem_cnt_o, bus.mem_busy_o);
        end
        bus.rdy = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        drive_ex(OP_LOAD, 3'd2, 5'd12, 1'b1, 32'h0, 32'hA0);
        step();
        bus.mem_stall_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.mem_cnt_i = 4'(i);
            step();
        end
        checks++;
        if (bus.mem_cnt_o !== 4'd3 || bus.mem_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_lw_cnt: cnt=%0d busy=%b expected 3/1", bus.mem_cnt_o, bus.mem_busy_o);
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.opcode_o !== 7'd0 || bus.mem_addr_o !== 32'd0 || bus.wd_o !== 5'd0 ||
            bus.wreg_o !== 1'b0 || bus.mem_cnt_o !== 4'd8 || bus.mem_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: op=%h addr=%h cnt=%0d busy=%b expected 0/0/8/0",
                     bus.opcode_o, bus.mem_addr_o, bus.mem_cnt_o, bus.mem_busy_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_stall_i = 1'b0;
        drive_ex(OP_IMM, 3'd0, 5'd6, 1'b1, 32'h77, 32'h0);
        step();
        checks++;
        if (bus.wdata_o !== 32'h77 || bus.wd_o !== 5'd6 || bus.mem_cnt_o !== 4'd8) begin
            failures++;
            $display("FAIL post_reset_capture: wdata=%h wd=%0d cnt=%0d expected 77/6/8",
                     bus.wdata_o, bus.wd_o, bus.mem_cnt_o);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [4];
        ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_IMM; ops[3] = OP_REG;
        for (int n = 0; n < 400; n++) begin
            drive_ex(ops[$urandom_range(0, 3)], 3'($urandom), 5'($urandom), 1'($urandom),
                     32'($urandom), 32'($urandom));
            bus.rdy         = ($urandom_range(0, 9) != 0);
            bus.mem_stall_i = ($urandom_range(0, 2) != 0);
            bus.ex_stall_i  = ($urandom_range(0, 4) == 0);
            bus.mem_cnt_i   = 4'($urandom_range(0, 15));
            step();
            checks++;
            if (bus.opcode_o !== m_opcode || bus.funct3_o !== m_funct3 || bus.wd_o !== m_wd ||
                bus.wreg_o !== m_wreg || bus.wdata_o !== m_wdata || bus.mem_addr_o !== m_addr) begin
                failures++;
                $display("FAIL rand_payload@%0d: op=%h f3=%0d wd=%0d wreg=%b wdata=%h addr=%h expected %h/%0d/%0d/%b/%h/%h",
                         n, bus.opcode_o, bus.funct3_o, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.mem_addr_o,
                         m_opcode, m_funct3, m_wd, m_wreg, m_wdata, m_addr);
            end
            checks++;
            if (int'(bus.mem_cnt_o) != m_cnt || bus.mem_busy_o !== m_busy() ||
                bus.mem_timeout_o !== 1'b0) begin
                failures++;
                $display("FAIL rand_cnt@%0d: cnt=%0d busy=%b tmo=%b expected %0d/%b/0",
                         n, bus.mem_cnt_o, bus.mem_busy_o, bus.mem_timeout_o, m_cnt, m_busy());
            end
        end
        bus.rdy = 1'b1; bus.mem_stall_i = 1'b0; bus.ex_stall_i = 1'b0;
    endtask

`ifdef MEM_WDOG_EN
    task automatic test_wdog();
        int edges;
        drive_ex(OP_LOAD, 3'd1, 5'd8, 1'b1, 32'h0, 32'h50);
        step();
        bus.mem_stall_i = 1'b1;
        bus.mem_cnt_i   = 4'd1;
        edges = 0;
        while (bus.mem_cnt_o != 4'd8 && edges < 60) begin
            step();
            edges++;
        end
        // 32 counted busy cycles, then the next edge aborts the access
        checks++;
        if (edges != 33 || bus.mem_timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL wdog_fire: edges=%0d tmo=%b expected 33/1", edges, bus.mem_timeout_o);
        end
        bus.mem_stall_i = 1'b0;
        drive_ex(OP_IMM, 3'd0, 5'd1, 1'b1, 32'h1, 32'h0);
        repeat (3) step();
        checks++;
        if (bus.mem_timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL wdog_sticky: tmo=%b expected 1", bus.mem_timeout_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_lw_sequence();
        test_done_stalled();
        test_bubble_rdy();
        test_reset_mid_access();
`ifdef MEM_WDOG_EN
        test_wdog();
`else
        test_random();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_ex_mem.md
Name: stage_ex_mem

Overview:
- Pipeline register between the execute stage and the memory stage.
- Latches the EX result and memory-access descriptor: opcode, funct3, destination, write data and address.
- Owns the byte-access sequencing counter that the memory stage reads back as mem_cnt each cycle. The memory stage walks its multi-cycle byte-serial LB/LH/LW/SB/SH/SW sequence through this counter.
- Handles stall-driven hold and bubble insertion.

Parameters:
- CNT_W, 4, width of the byte-access counter.
- CNT_DONE, 4'b1000, counter value meaning "access complete"; the counter saturates here.
- WDOG_LIMIT, 32, cycles an access may stay incomplete before the watchdog fires (only with MEM_WDOG_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0, acts immediately, released synchronously by the top level).
- rdy  in  1  global ready; 0 freezes every register.
- ex_opcode_i  in  7  opcode from EX.
- ex_funct3_i  in  3  funct3 from EX.
- ex_wd_i  in  5  destination register address.
- ex_wreg_i  in  1  register write enable.
- ex_wdata_i  in  32  ALU result or store data.
- ex_mem_addr_i  in  32  effective memory address.
- ex_stall_i  in  1  controller stalls EX.
- mem_stall_i  in  1  controller stalls MEM or a later stage.
- mem_cnt_i  in  CNT_W  next counter value returned by the memory stage.
- opcode_o  out  7  latched opcode.
- funct3_o  out  3  latched funct3.
- wd_o  out  5  latched destination.
- wreg_o  out  1  latched write enable.
- wdata_o  out  32  latched data.
- mem_addr_o  out  32  latched address.
- mem_cnt_o  out  CNT_W  current counter value, to the memory stage.
- mem_busy_o  out  1  access in progress.
- mem_timeout_o  out  1  sticky watchdog flag (0 when the feature is off).

Behaviour:
- Reset (rst=0, asynchronous):
  - opcode_o=7'b0, funct3_o=0, wd_o=0, wreg_o=0, wdata_o=0, mem_addr_o=0.
  - mem_cnt_o=CNT_DONE, mem_timeout_o=0.
  - Reset mid-access abandons the access; no partial state survives.
- rdy=0: all registers hold; mem_cnt_i is ignored.
- Classification: mem_op = (opcode_o is LOAD or STORE).
- mem_busy_o = mem_op && mem_cnt_o != CNT_DONE. This output is combinational.
- Per rising edge with rdy=1, priority order:
  1. mem_stall_i=1: payload registers hold.
     - If mem_busy_o=1: mem_cnt_o <= mem_cnt_i.
     - Otherwise the counter holds, saturated at CNT_DONE.
     - For non-memory opcodes mem_cnt_i is never sampled; the memory stage does not drive it for them.
  2. mem_stall_i=0, ex_stall_i=1: insert a bubble.
     - All payload outputs go to 0; mem_cnt_o <= CNT_DONE.
  3. mem_stall_i=0, ex_stall_i=0: capture all ex_* inputs.
     - mem_cnt_o <= 0 if ex_opcode_i is LOAD/STORE, else CNT_DONE.
- Latency: one cycle from EX to MEM outputs.
- The counter advances exactly one step per cycle as dictated by mem_cnt_i. This module does not interpret intermediate counter values.
- A completed access (mem_cnt_i=CNT_DONE) with a downstream stall still asserted leaves the counter at CNT_DONE. The memory stage therefore never restarts the access.
- Back-to-back memory instructions: a new capture on the edge after completion restarts the counter at 0.
- mem_cnt_i values above CNT_DONE are treated as CNT_DONE.

Optional Feature:
- Macro: MEM_WDOG_EN.
- Enabled:
  - An internal counter clears on every capture or bubble and increments each rdy cycle while mem_busy_o=1.
  - When it reaches WDOG_LIMIT, the next edge forces mem_cnt_o=CNT_DONE and sets mem_timeout_o=1.
  - mem_timeout_o clears only on reset.
- Disabled: no watchdog logic exists and mem_timeout_o is tied to 0.

Decomposition:
- Shared defines header holds:
  - LOAD_OP/STORE_OP opcodes.
  - Bus widths (OpcodeBus, FunctBus3, RegAddrBus, RegBus, InstAddrBus, CntBus8).
  - NOPRegAddr, ZeroWord.
  - CNT_DONE and the reset-polarity constant.
- Optional sub-module mem_wdog (watchdog counter plus sticky flag) is instantiated only under MEM_WDOG_EN. Everything else stays flat.

Test Plan:
- Reset: drive rst=0 mid-LW at cnt=3 → all outputs zero immediately, mem_cnt_o=4'b1000; after release, the next capture works normally.
- ALU op: ADDI result 0x0000_002A, wd=5, no stalls → next cycle wdata_o=0x2A, wd_o=5, wreg_o=1, mem_cnt_o=8, mem_busy_o=0.
- LW sequence: capture with addr 0x100, then hold mem_stall_i=1 while mem_cnt_i steps 1..8.
  - mem_cnt_o must follow 0,1,…,7,8 one cycle behind each step, and mem_busy_o must drop when it reaches 8.
  - The payload must stay unchanged throughout.
- Done-while-stalled: after an SB completes (cnt=8), keep mem_stall_i=1 and drive mem_cnt_i=1 → mem_cnt_o stays 8 for 3 cycles.
- Bubble vs rdy:
  - ex_stall_i=1, mem_stall_i=0 → outputs zero.
  - rdy=0 with a new ex_* input → outputs unchanged.
- Watchdog (MEM_WDOG_EN, WDOG_LIMIT=32): LH with mem_cnt_i stuck at 1 → after 32 busy cycles mem_cnt_o=8 and mem_timeout_o=1, and the flag stays 1 across later instructions.
